// File: rtl/lfsr_check_if.sv
// Stream and status bundle between an LFSR bit source and the lfsr_check receiver.
// Signal suffixes are from the checker's point of view.
interface lfsr_check_if;
  logic        valid_i;
  logic        data_i;
  logic        clear_i;
  logic        locked_o;
  logic        err_o;
  logic [15:0] err_count_o;

  modport master (
    output valid_i, data_i, clear_i,
    input  locked_o, err_o, err_count_o
  );

  modport slave (
    input  valid_i, data_i, clear_i,
    output locked_o, err_o, err_count_o
  );
endinterface

// File: rtl/lfsr_check.sv
// Serial self-seeding checker for a Fibonacci LFSR bit stream; flags mismatching bits.
// Optional saturating error counter built when LFSR_CHECK_ERR_COUNT_EN is defined.
module lfsr_check #(
  parameter int width_p     = 11,
  parameter int tap_a_p     = 10,
  parameter int tap_b_p     = 1,
  parameter int lock_loss_p = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,
  lfsr_check_if.slave  bus
);

  localparam int seed_w = $clog2(width_p + 1);

  typedef enum logic {
    SEED,
    CHECK
  } state_e;

  state_e               state_q, state_d;
  logic [width_p-1:0]   h_q, h_d;
  logic [seed_w-1:0]    seed_cnt_q, seed_cnt_d;
  logic [3:0]           miss_q, miss_d;
  logic                 locked_q, locked_d;
  logic                 err_q, err_d;
  logic                 expected_bit;
  logic [width_p-1:0]   h_seeded;

  assign expected_bit = h_q[tap_a_p] ^ h_q[tap_b_p];
  assign h_seeded     = {h_q[width_p-2:0], bus.data_i};

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d    = state_q;
    h_d        = h_q;
    seed_cnt_d = seed_cnt_q;
    miss_d     = miss_q;
    locked_d   = locked_q;
    err_d      = 1'b0;

    if (bus.valid_i) begin
      unique case (state_q)
        SEED: begin
          h_d = h_seeded;
          if (seed_cnt_q == seed_w'(width_p - 1)) begin
            seed_cnt_d = '0;
            // An all-zero history is the LFSR lock-up state, so seeding restarts.
            if (h_seeded != '0) begin
              state_d  = CHECK;
              locked_d = 1'b1;
            end
          end else begin
            seed_cnt_d = seed_cnt_q + 1'b1;
          end
        end
        CHECK: begin
          // Shift in the prediction, not the line bit, so one line error costs one error.
          h_d = {h_q[width_p-2:0], expected_bit};
          if (bus.data_i != expected_bit) begin
            err_d = 1'b1;
            if (miss_q + 4'd1 == 4'(lock_loss_p)) begin
              state_d    = SEED;
              locked_d   = 1'b0;
              seed_cnt_d = '0;
              miss_d     = '0;
              h_d        = '0;
            end else begin
              miss_d = miss_q + 4'd1;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: state_d = SEED;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= SEED;
      h_q        <= '0;
      seed_cnt_q <= '0;
      miss_q     <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      h_q        <= h_d;
      seed_cnt_q <= seed_cnt_d;
      miss_q     <= miss_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
    end
  end

  assign bus.locked_o = locked_q;
  assign bus.err_o    = err_q;

`ifdef LFSR_CHECK_ERR_COUNT_EN
  logic [15:0] err_count_q, err_count_d;

  // Clear wins over the stale count but still records an error arriving with it.
  always_comb begin
    err_count_d = err_count_q;
    if (bus.clear_i) begin
      err_count_d = {15'd0, err_d};
    end else if (err_d && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign bus.err_count_o = err_count_q;
`else
  logic unused_clear;
  assign unused_clear    = bus.clear_i;
  assign bus.err_count_o = '0;
`endif

endmodule

// File: tb/tb_lfsr_check.sv
// Scoreboard bench for lfsr_check: a reference model pushes expected outputs per driven
// cycle, which are popped and compared one edge later. Honours LFSR_CHECK_ERR_COUNT_EN.
module tb_lfsr_check;

`ifdef LFSR_CHECK_ERR_COUNT_EN
  localparam bit cnt_en = 1'b1;
`else
  localparam bit cnt_en = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lfsr_check_if bus ();

  lfsr_check dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  typedef struct packed {
    logic        locked;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   err_seen = 0;

  // Reference model state
  logic        m_locked, m_err;
  logic [10:0] m_h;
  int          m_seed, m_miss, m_cnt;

  // Generator state
  logic [10:0] g;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 25) $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic model(input logic v, input logic d, input logic clr, input logic rst);
    logic e;
    if (rst) begin
      m_locked = 1'b0; m_err = 1'b0; m_h = '0;
      m_seed = 0; m_miss = 0; m_cnt = 0;
      return;
    end
    m_err = 1'b0;
    if (v) begin
      if (!m_locked) begin
        m_h = {m_h[9:0], d};
        m_seed++;
        if (m_seed == 11) begin
          m_seed = 0;
          if (m_h != 11'd0) m_locked = 1'b1;
        end
      end else begin
        e   = m_h[10] ^ m_h[1];
        m_h = {m_h[9:0], e};
        if (d != e) begin
          m_err = 1'b1;
          m_miss++;
          if (m_miss == 4) begin
            m_locked = 1'b0; m_seed = 0; m_miss = 0; m_h = '0;
          end
        end else begin
          m_miss = 0;
        end
      end
    end
    if (cnt_en) begin
      if (clr) m_cnt = m_err ? 1 : 0;
      else if (m_err && m_cnt < 65535) m_cnt++;
    end
  endtask

  task automatic cycle(input logic v, input logic d, input logic clr = 1'b0, input logic rst = 1'b0);
    exp_t ex;
    bus.valid_i = v;
    bus.data_i  = d;
    bus.clear_i = clr;
    reset       = rst;
    model(v, d, clr, rst);
    sb_q.push_back('{locked: m_locked, err: m_err, cnt: m_cnt[15:0]});
    @(posedge clk);
    @(negedge clk);
    ex = sb_q.pop_front();
    check("locked", {15'd0, bus.locked_o}, {15'd0, ex.locked});
    check("err", {15'd0, bus.err_o}, {15'd0, ex.err});
    check("err_count", bus.err_count_o, ex.cnt);
    err_seen += int'(bus.err_o);
  endtask

  task automatic gen_bit(output logic b);
    b = g[10] ^ g[1];
    g = {g[9:0], b};
  endtask

  task automatic send_good(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      gen_bit(b);
      cycle(1'b1, b);
    end
  endtask

  task automatic send_bad(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      gen_bit(b);
      cycle(1'b1, ~b);
    end
  endtask

  initial begin
    logic b;
    int   acc;
    bus.valid_i = 1'b0;
    bus.data_i  = 1'b0;
    bus.clear_i = 1'b0;
    reset       = 1'b1;
    @(negedge clk);

    // Reset, including reset asserted alongside valid data
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    check("rst_locked", {15'd0, bus.locked_o}, 16'd0);
    check("rst_count", bus.err_count_o, 16'd0);

    // Continuous clean stream from seed 1
    g = 11'h001;
    err_seen = 0;
    send_good(10);
    check("lock_before_11", {15'd0, bus.locked_o}, 16'd0);
    send_good(1);
    check("lock_at_11", {15'd0, bus.locked_o}, 16'd1);
    send_good(1989);
    check("clean_2000_errs", 16'(err_seen), 16'd0);

    // Same stream with ~30% idle cycles
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    g = 11'h001;
    err_seen = 0;
    acc = 0;
    while (acc < 600) begin
      if ($urandom_range(99) < 30) begin
        cycle(1'b0, logic'($urandom_range(1)));
      end else begin
        gen_bit(b);
        cycle(1'b1, b);
        acc++;
        if (acc == 10) check("gap_lock_before_11", {15'd0, bus.locked_o}, 16'd0);
        if (acc == 11) check("gap_lock_at_11", {15'd0, bus.locked_o}, 16'd1);
      end
    end
    check("gap_errs", 16'(err_seen), 16'd0);

    // All-zero seed is rejected, then a clean stream locks
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    err_seen = 0;
    repeat (11) cycle(1'b1, 1'b0);
    check("zero_seed_locked", {15'd0, bus.locked_o}, 16'd0);
    check("zero_seed_errs", 16'(err_seen), 16'd0);
    g = 11'h001;
    send_good(10);
    check("zero_then_lock_early", {15'd0, bus.locked_o}, 16'd0);
    send_good(1);
    check("zero_then_lock", {15'd0, bus.locked_o}, 16'd1);

    // Single inverted bit at post-lock position 20
    send_good(19);
    err_seen = 0;
    send_bad(1);
    check("single_err_pulse", {15'd0, bus.err_o}, 16'd1);
    send_good(30);
    check("single_err_total", 16'(err_seen), 16'd1);
    check("single_locked", {15'd0, bus.locked_o}, 16'd1);
    check("single_count", bus.err_count_o, cnt_en ? 16'd1 : 16'd0);

    // Four consecutive errors drop lock; relock after 11 bits
    err_seen = 0;
    send_bad(3);
    check("miss3_locked", {15'd0, bus.locked_o}, 16'd1);
    send_bad(1);
    check("miss4_unlocked", {15'd0, bus.locked_o}, 16'd0);
    check("miss4_errs", 16'(err_seen), 16'd4);
    send_good(10);
    check("relock_early", {15'd0, bus.locked_o}, 16'd0);
    send_good(1);
    check("relock", {15'd0, bus.locked_o}, 16'd1);
    send_good(5);
    send_bad(3);
    send_good(1);
    check("miss3_good_locked", {15'd0, bus.locked_o}, 16'd1);
    send_good(10);

    // Clear together with an error
    gen_bit(b);
    cycle(1'b1, ~b, 1'b1);
    check("clear_with_err", bus.err_count_o, cnt_en ? 16'd1 : 16'd0);
    send_good(4);

`ifdef LFSR_CHECK_ERR_COUNT_EN
    // Drive the counter into saturation without losing lock
    repeat (21845) begin
      send_bad(3);
      send_good(1);
    end
    check("sat_count", bus.err_count_o, 16'hFFFF);
    send_bad(2);
    send_good(1);
    check("sat_hold", bus.err_count_o, 16'hFFFF);
    gen_bit(b);
    cycle(1'b1, ~b, 1'b1);
    check("sat_clear_with_err", bus.err_count_o, 16'd1);
    send_good(4);
`endif

    // Reset while locked
    check("pre_reset_locked", {15'd0, bus.locked_o}, 16'd1);
    gen_bit(b);
    cycle(1'b1, b, 1'b0, 1'b1);
    check("reset_locked", {15'd0, bus.locked_o}, 16'd0);
    check("reset_count", bus.err_count_o, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
